// File: rtl/control_sequencer.sv
// Instruction-cycle sequencer: steps IF/ID/EX/MEM/WB, sizes the MEM stage,
// drives fetch/PC strobes and injects the interrupt-call pass between instructions.
package control_sequencer_pkg;

  localparam int unsigned STATE_COUNT  = 3;
  localparam int unsigned OPCODE_COUNT = 5;
  localparam int unsigned GROUP_COUNT  = 4;

  typedef enum logic [STATE_COUNT-1:0] {
    STATE_IF  = 3'd0,
    STATE_ID  = 3'd1,
    STATE_EX  = 3'd2,
    STATE_MEM = 3'd3,
    STATE_WB  = 3'd4
  } state_e;

  localparam logic [OPCODE_COUNT-1:0] TYPE_NOP      = 5'd0;
  localparam logic [OPCODE_COUNT-1:0] TYPE_ADD      = 5'd1;
  localparam logic [OPCODE_COUNT-1:0] TYPE_LD       = 5'd2;
  localparam logic [OPCODE_COUNT-1:0] TYPE_RET      = 5'd3;
  localparam logic [OPCODE_COUNT-1:0] TYPE_RETI     = 5'd4;
  localparam logic [OPCODE_COUNT-1:0] TYPE_RCALL    = 5'd5;
  localparam logic [OPCODE_COUNT-1:0] TYPE_CALL_ISR = 5'd6;

  // Instructions that move two PC bytes through the stack need a second MEM cycle.
  function automatic logic two_cycle_mem(input logic [OPCODE_COUNT-1:0] op);
    return (op == TYPE_RET) || (op == TYPE_RETI) ||
           (op == TYPE_RCALL) || (op == TYPE_CALL_ISR);
  endfunction

endpackage

module control_sequencer
  import control_sequencer_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic [OPCODE_COUNT-1:0] opcode_type,
  input  logic [GROUP_COUNT-1:0]  opcode_group,
  input  logic                    stall,
  input  logic                    irq_request,
  input  logic                    int_enable,
  output logic [STATE_COUNT-1:0]  state,
  output logic                    cycle_count,
  output logic                    ir_load,
  output logic                    pc_advance,
  output logic                    isr_pending,
  output logic                    isr_ack
);

  state_e state_q, state_d;
  logic   cycle_q, cycle_d;
  logic   two_cyc_q, two_cyc_d;
  logic   pending_q, pending_d;
  logic   ack_q, ack_d;
  logic   take_c;

  // Group flags only matter to the signal generation unit downstream.
  logic   unused_group_c;
  assign unused_group_c = ^opcode_group;

  // RETI must retire one more instruction before another interrupt is taken.
  assign take_c = irq_request && int_enable && !pending_q &&
                  (opcode_type != TYPE_RETI);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= STATE_IF;
      cycle_q   <= 1'b0;
      two_cyc_q <= 1'b0;
      pending_q <= 1'b0;
      ack_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cycle_q   <= cycle_d;
      two_cyc_q <= two_cyc_d;
      pending_q <= pending_d;
      ack_q     <= ack_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cycle_d   = cycle_q;
    two_cyc_d = two_cyc_q;
    pending_d = pending_q;
    ack_d     = 1'b0;
    if (!stall) begin
      case (state_q)
        STATE_IF: begin
          state_d = STATE_ID;
          cycle_d = 1'b0;
        end
        STATE_ID: begin
          state_d = STATE_EX;
          cycle_d = 1'b0;
        end
        STATE_EX: begin
          state_d   = STATE_MEM;
          cycle_d   = 1'b0;
          two_cyc_d = two_cycle_mem(opcode_type);
        end
        STATE_MEM: begin
          if (two_cyc_q && !cycle_q) begin
            cycle_d = 1'b1;
          end else begin
            state_d = STATE_WB;
            cycle_d = 1'b0;
          end
        end
        STATE_WB: begin
          state_d = STATE_IF;
          cycle_d = 1'b0;
          if (pending_q) begin
            pending_d = 1'b0;
          end else if (take_c) begin
            pending_d = 1'b1;
            ack_d     = 1'b1;
          end
        end
        default: begin
          state_d = STATE_IF;
          cycle_d = 1'b0;
        end
      endcase
    end
  end

  assign state       = state_q;
  assign cycle_count = cycle_q;
  assign isr_pending = pending_q;
  assign isr_ack     = ack_q;

  // Strobes react to stall within the same cycle, so they stay combinational.
  assign ir_load    = (state_q == STATE_IF) && !stall && !pending_q;
  assign pc_advance = (state_q == STATE_WB) && !stall;

endmodule

// File: tb/tb_control_sequencer.sv
// Vector-table bench for control_sequencer with a queue of expected outputs
// and a latency check for whole instructions.
module tb_control_sequencer;
  import control_sequencer_pkg::*;

  typedef struct packed {
    logic [STATE_COUNT-1:0] st;
    logic                   cc;
    logic                   irl;
    logic                   pca;
    logic                   pend;
    logic                   ack;
  } exp_t;

  typedef struct packed {
    logic                    rst;
    logic                    stl;
    logic                    irq;
    logic                    ie;
    logic [OPCODE_COUNT-1:0] op;
    exp_t                    exp;
  } vec_t;

  logic                    clk = 1'b0;
  logic                    reset = 1'b1;
  logic [OPCODE_COUNT-1:0] opcode_type = TYPE_NOP;
  logic [GROUP_COUNT-1:0]  opcode_group = '0;
  logic                    stall = 1'b0;
  logic                    irq_request = 1'b0;
  logic                    int_enable = 1'b0;
  logic [STATE_COUNT-1:0]  state;
  logic                    cycle_count;
  logic                    ir_load;
  logic                    pc_advance;
  logic                    isr_pending;
  logic                    isr_ack;

  vec_t vecs[$];
  exp_t exp_q[$];
  int   lat_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  control_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .opcode_type  (opcode_type),
    .opcode_group (opcode_group),
    .stall        (stall),
    .irq_request  (irq_request),
    .int_enable   (int_enable),
    .state        (state),
    .cycle_count  (cycle_count),
    .ir_load      (ir_load),
    .pc_advance   (pc_advance),
    .isr_pending  (isr_pending),
    .isr_ack      (isr_ack)
  );

  always #5 clk = ~clk;

  task automatic add(input logic rst, input logic stl, input logic irq, input logic ie,
                     input logic [OPCODE_COUNT-1:0] op, input state_e st, input logic cc,
                     input logic irl, input logic pca, input logic pend, input logic ack);
    vec_t v;
    v.rst = rst; v.stl = stl; v.irq = irq; v.ie = ie; v.op = op;
    v.exp.st = st; v.exp.cc = cc; v.exp.irl = irl; v.exp.pca = pca;
    v.exp.pend = pend; v.exp.ack = ack;
    vecs.push_back(v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // ADD, unstalled
    add(0,0,0,0,TYPE_NOP,      STATE_IF, 0,1,0,0,0);
    add(0,0,0,0,TYPE_ADD,      STATE_ID, 0,0,0,0,0);
    add(0,0,0,0,TYPE_ADD,      STATE_EX, 0,0,0,0,0);
    add(0,0,0,0,TYPE_ADD,      STATE_MEM,0,0,0,0,0);
    add(0,0,0,0,TYPE_ADD,      STATE_WB, 0,0,1,0,0);
    // RET: opcode changes during MEM must not shorten it
    add(0,0,0,0,TYPE_NOP,      STATE_IF, 0,1,0,0,0);
    add(0,0,0,0,TYPE_RET,      STATE_ID, 0,0,0,0,0);
    add(0,0,0,0,TYPE_RET,      STATE_EX, 0,0,0,0,0);
    add(0,0,0,0,TYPE_ADD,      STATE_MEM,0,0,0,0,0);
    add(0,0,0,0,TYPE_ADD,      STATE_MEM,1,0,0,0,0);
    add(0,0,0,0,TYPE_RET,      STATE_WB, 0,0,1,0,0);
    // LD with a 3-cycle stall in EX and a 1-cycle stall in WB
    add(0,0,0,0,TYPE_NOP,      STATE_IF, 0,1,0,0,0);
    add(0,0,0,0,TYPE_LD,       STATE_ID, 0,0,0,0,0);
    add(0,1,0,0,TYPE_LD,       STATE_EX, 0,0,0,0,0);
    add(0,1,0,0,TYPE_LD,       STATE_EX, 0,0,0,0,0);
    add(0,1,0,0,TYPE_LD,       STATE_EX, 0,0,0,0,0);
    add(0,0,0,0,TYPE_LD,       STATE_EX, 0,0,0,0,0);
    add(0,0,0,0,TYPE_LD,       STATE_MEM,0,0,0,0,0);
    add(0,1,0,0,TYPE_LD,       STATE_WB, 0,0,0,0,0);
    add(0,0,0,0,TYPE_LD,       STATE_WB, 0,0,1,0,0);
    // NOP retires with an interrupt pending, then the injected pass
    add(0,0,0,0,TYPE_NOP,      STATE_IF, 0,1,0,0,0);
    add(0,0,0,0,TYPE_NOP,      STATE_ID, 0,0,0,0,0);
    add(0,0,0,0,TYPE_NOP,      STATE_EX, 0,0,0,0,0);
    add(0,0,0,0,TYPE_NOP,      STATE_MEM,0,0,0,0,0);
    add(0,0,1,1,TYPE_NOP,      STATE_WB, 0,0,1,0,0);
    add(0,0,1,1,TYPE_CALL_ISR, STATE_IF, 0,0,0,1,1);
    add(0,0,1,1,TYPE_CALL_ISR, STATE_ID, 0,0,0,1,0);
    add(0,0,1,1,TYPE_CALL_ISR, STATE_EX, 0,0,0,1,0);
    add(0,0,1,1,TYPE_CALL_ISR, STATE_MEM,0,0,0,1,0);
    add(0,0,1,1,TYPE_CALL_ISR, STATE_MEM,1,0,0,1,0);
    add(0,0,1,1,TYPE_CALL_ISR, STATE_WB, 0,0,1,1,0);
    add(0,0,1,1,TYPE_NOP,      STATE_IF, 0,1,0,0,0);
    // RETI with irq held: no take until the following instruction retires
    add(0,0,1,1,TYPE_RETI,     STATE_ID, 0,0,0,0,0);
    add(0,0,1,1,TYPE_RETI,     STATE_EX, 0,0,0,0,0);
    add(0,0,1,1,TYPE_RETI,     STATE_MEM,0,0,0,0,0);
    add(0,0,1,1,TYPE_RETI,     STATE_MEM,1,0,0,0,0);
    add(0,0,1,1,TYPE_RETI,     STATE_WB, 0,0,1,0,0);
    add(0,0,1,1,TYPE_NOP,      STATE_IF, 0,1,0,0,0);
    add(0,0,1,1,TYPE_ADD,      STATE_ID, 0,0,0,0,0);
    add(0,0,1,1,TYPE_ADD,      STATE_EX, 0,0,0,0,0);
    add(0,0,1,1,TYPE_ADD,      STATE_MEM,0,0,0,0,0);
    add(0,0,1,1,TYPE_ADD,      STATE_WB, 0,0,1,0,0);
    // Stalled first IF of the pass keeps ack to one cycle; reset in second MEM
    add(0,1,1,1,TYPE_CALL_ISR, STATE_IF, 0,0,0,1,1);
    add(0,0,1,1,TYPE_CALL_ISR, STATE_IF, 0,0,0,1,0);
    add(0,0,1,1,TYPE_RCALL,    STATE_ID, 0,0,0,1,0);
    add(0,0,1,1,TYPE_RCALL,    STATE_EX, 0,0,0,1,0);
    add(0,0,1,1,TYPE_RCALL,    STATE_MEM,0,0,0,1,0);
    add(1,0,1,1,TYPE_RCALL,    STATE_MEM,1,0,0,1,0);
    add(0,0,0,0,TYPE_NOP,      STATE_IF, 0,1,0,0,0);
    // int_enable low blocks the take
    add(0,0,0,0,TYPE_ADD,      STATE_ID, 0,0,0,0,0);
    add(0,0,0,0,TYPE_ADD,      STATE_EX, 0,0,0,0,0);
    add(0,0,0,0,TYPE_ADD,      STATE_MEM,0,0,0,0,0);
    add(0,0,1,0,TYPE_ADD,      STATE_WB, 0,0,1,0,0);
    add(0,0,1,0,TYPE_NOP,      STATE_IF, 0,1,0,0,0);
    // Stalled WB defers the take to the unstalled edge; reset in the pass
    add(0,0,0,0,TYPE_NOP,      STATE_ID, 0,0,0,0,0);
    add(0,0,0,0,TYPE_NOP,      STATE_EX, 0,0,0,0,0);
    add(0,0,0,0,TYPE_NOP,      STATE_MEM,0,0,0,0,0);
    add(0,1,1,1,TYPE_NOP,      STATE_WB, 0,0,0,0,0);
    add(0,0,1,1,TYPE_NOP,      STATE_WB, 0,0,1,0,0);
    add(0,0,0,0,TYPE_CALL_ISR, STATE_IF, 0,0,0,1,1);
    add(1,0,0,0,TYPE_CALL_ISR, STATE_ID, 0,0,0,1,0);
    add(0,0,0,0,TYPE_NOP,      STATE_IF, 0,1,0,0,0);
    // RET stalled in second MEM; irq dropped before WB is never taken
    add(0,0,0,0,TYPE_RET,      STATE_ID, 0,0,0,0,0);
    add(0,0,0,0,TYPE_RET,      STATE_EX, 0,0,0,0,0);
    add(0,0,1,1,TYPE_RET,      STATE_MEM,0,0,0,0,0);
    add(0,1,1,1,TYPE_RET,      STATE_MEM,1,0,0,0,0);
    add(0,0,1,1,TYPE_RET,      STATE_MEM,1,0,0,0,0);
    add(0,0,0,1,TYPE_RET,      STATE_WB, 0,0,1,0,0);
    add(0,0,0,1,TYPE_NOP,      STATE_IF, 0,1,0,0,0);

    reset = 1'b1;
    @(posedge clk);
    foreach (vecs[i]) begin
      exp_t act;
      exp_t want;
      @(posedge clk);
      #1;
      reset       = vecs[i].rst;
      stall       = vecs[i].stl;
      irq_request = vecs[i].irq;
      int_enable  = vecs[i].ie;
      opcode_type = vecs[i].op;
      exp_q.push_back(vecs[i].exp);
      @(negedge clk);
      act  = '{st: state, cc: cycle_count, irl: ir_load, pca: pc_advance,
               pend: isr_pending, ack: isr_ack};
      want = exp_q.pop_front();
      n_vec++;
      if (act !== want) begin
        n_err++;
        $display("FAIL vec %0d: got st=%0d cc=%0b ir_load=%0b pc_adv=%0b pend=%0b ack=%0b, want st=%0d cc=%0b ir_load=%0b pc_adv=%0b pend=%0b ack=%0b",
                 i, act.st, act.cc, act.irl, act.pca, act.pend, act.ack,
                 want.st, want.cc, want.irl, want.pca, want.pend, want.ack);
      end
    end

    // Whole-instruction latency from IF back to IF, unstalled
    reset = 1'b0; stall = 1'b0; irq_request = 1'b0; int_enable = 1'b0;
    for (int k = 0; k < 4; k++) begin
      logic [OPCODE_COUNT-1:0] op;
      int cnt;
      case (k)
        0:       op = TYPE_ADD;
        1:       op = TYPE_RCALL;
        2:       op = TYPE_LD;
        default: op = TYPE_RETI;
      endcase
      lat_q.push_back(two_cycle_mem_ref(op) ? 6 : 5);
      opcode_type = op;
      cnt = 0;
      do begin
        @(posedge clk);
        #1;
        cnt++;
      end while ((state != STATE_IF) && (cnt < 20));
      n_vec++;
      begin
        int want_lat;
        want_lat = lat_q.pop_front();
        if (cnt != want_lat) begin
          n_err++;
          $display("FAIL latency op=%0d: got %0d cycles, want %0d", op, cnt, want_lat);
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  function automatic logic two_cycle_mem_ref(input logic [OPCODE_COUNT-1:0] op);
    return (op == TYPE_RET) || (op == TYPE_RETI) || (op == TYPE_RCALL) || (op == TYPE_CALL_ISR);
  endfunction

endmodule
